// File: rtl/throttle_ctrl.sv
// Push-button speed throttle: debounced up/down buttons step a level with
// hold-to-repeat, and the level selects the half-period of a divided clock.
module throttle_ctrl #(
    parameter int DB_DEPTH    = 8,
    parameter int LEVELS      = 6,
    parameter int LVL_W       = 3,
    parameter int RESET_LEVEL = 0,
    parameter int BASE_HALF   = 2,
    parameter int DIV_W       = 24,
    parameter int REPEAT_DLY  = 25000000,
    parameter int REPEAT_RATE = 5000000,
    parameter int RPT_W       = 25
) (
    input  logic             CLK_50,
    input  logic             reset,
    input  logic             pb_freq_up,
    input  logic             pb_freq_dn,
    output logic             slow_clk,
    output logic             tick,
    output logic [LVL_W-1:0] freq_num,
    output logic             at_min,
    output logic             at_max
);

    localparam logic [LVL_W-1:0] MAX_LVL   = LVL_W'(LEVELS - 1);
    localparam logic [LVL_W-1:0] RST_LVL   = LVL_W'(RESET_LEVEL);
    localparam logic [DIV_W-1:0] BASE      = DIV_W'(BASE_HALF);
    localparam logic [DIV_W-1:0] RST_HALF  = BASE << (LEVELS - 1 - RESET_LEVEL);
    localparam logic [RPT_W-1:0] DLY_LOAD  = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] RATE_LOAD = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RPT
    } state_t;

    // Button index 0 is up, 1 is down.
    logic [1:0]                sync1_q, sync1_d;
    logic [1:0]                sync2_q, sync2_d;
    logic [1:0][DB_DEPTH-1:0]  shift_q, shift_d;
    logic [1:0]                db_q, db_d;
    logic [1:0]                db_prev_q, db_prev_d;

    state_t                    state_q, state_d;
    logic                      dir_up_q, dir_up_d;
    logic [RPT_W-1:0]          timer_q, timer_d;
    logic [LVL_W-1:0]          level_q, level_d;

    logic [DIV_W-1:0]          cnt_q, cnt_d;
    logic [DIV_W-1:0]          half_q, half_d;
    logic                      slow_q, slow_d;
    logic                      tick_q, tick_d;

    logic                      up, dn, up_edge, dn_edge, same_dir;
    logic                      step_up, step_dn, wrap;

    always_comb begin
        sync1_d = {pb_freq_dn, pb_freq_up};
        sync2_d = sync1_q;
        shift_d = shift_q;
        db_d    = db_q;
        for (int b = 0; b < 2; b++) begin
            shift_d[b] = (shift_q[b] << 1) | DB_DEPTH'(sync2_q[b]);
            if (&shift_q[b]) begin
                db_d[b] = 1'b1;
            end else if (~|shift_q[b]) begin
                db_d[b] = 1'b0;
            end
        end
        db_prev_d = db_q;
    end

    // Edges are taken on the raw debounced button, so releasing one of two
    // held buttons exposes a level on the other without producing a step.
    assign up       = db_q[0] & ~db_q[1];
    assign dn       = db_q[1] & ~db_q[0];
    assign up_edge  = up & ~db_prev_q[0];
    assign dn_edge  = dn & ~db_prev_q[1];
    assign same_dir = dir_up_q ? up : dn;

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        timer_d  = timer_q;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        case (state_q)
            IDLE: begin
                if (up_edge) begin
                    step_up  = 1'b1;
                    dir_up_d = 1'b1;
                    timer_d  = DLY_LOAD;
                    state_d  = HOLD;
                end else if (dn_edge) begin
                    step_dn  = 1'b1;
                    dir_up_d = 1'b0;
                    timer_d  = DLY_LOAD;
                    state_d  = HOLD;
                end
            end
            HOLD, RPT: begin
                if (!same_dir) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    step_up = dir_up_q;
                    step_dn = ~dir_up_q;
                    timer_d = RATE_LOAD;
                    state_d = RPT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (step_up && level_q != MAX_LVL) begin
            level_d = level_q + 1'b1;
        end else if (step_dn && level_q != '0) begin
            level_d = level_q - 1'b1;
        end
    end

    // The half-period is only re-latched at a wrap so a level change never
    // produces a runt or stretched phase on slow_clk.
    assign wrap = (cnt_q == half_q - 1'b1);

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        slow_d = wrap ? ~slow_q : slow_q;
        tick_d = wrap & ~slow_q;
        half_d = wrap ? (BASE << (MAX_LVL - level_q)) : half_q;
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            shift_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            state_q   <= IDLE;
            dir_up_q  <= 1'b0;
            timer_q   <= '0;
            level_q   <= RST_LVL;
            cnt_q     <= '0;
            half_q    <= RST_HALF;
            slow_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            shift_q   <= shift_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            state_q   <= state_d;
            dir_up_q  <= dir_up_d;
            timer_q   <= timer_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            slow_q    <= slow_d;
            tick_q    <= tick_d;
        end
    end

    assign slow_clk = slow_q;
    assign tick     = tick_q;
    assign freq_num = level_q;
    assign at_min   = (level_q == '0);
    assign at_max   = (level_q == MAX_LVL);

endmodule

// File: doc/throttle_ctrl.md
Name: throttle_ctrl

Overview:
- Parametrised next-generation throttle: two push-buttons step a speed level between 0 and LEVELS-1.
- Level selects the half-period of a divided clock derived from CLK_50.
- Adds over the first generation: synchronised debouncers of configurable depth, one step per press, hold-to-auto-repeat, saturation flags, glitch-free divisor changes and a single-cycle tick enable.
- Sits between the board push-buttons and any slow-rate consumer (LED chaser, stepper, display scan).

Parameters:
- DB_DEPTH, 8, debounce shift-register length (stable samples required).
- LEVELS, 6, number of speed levels (>=2).
- LVL_W, 3, level width; 2**LVL_W >= LEVELS.
- RESET_LEVEL, 0, level loaded on reset (< LEVELS).
- BASE_HALF, 2, half-period in CLK_50 cycles at level LEVELS-1 (>=1).
- DIV_W, 24, divider width; must hold BASE_HALF<<(LEVELS-1).
- REPEAT_DLY, 25000000, hold cycles before the first auto-repeat step.
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeat steps.
- RPT_W, 25, repeat-timer width.

Ports:
- CLK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high; clears all state.
- pb_freq_up  in  1  raw up button, asynchronous, active-high.
- pb_freq_dn  in  1  raw down button, asynchronous, active-high.
- slow_clk  out  1  divided clock, 50% duty.
- tick  out  1  one-cycle pulse coincident with each slow_clk 0->1 transition.
- freq_num  out  LVL_W  current level.
- at_min  out  1  freq_num == 0.
- at_max  out  1  freq_num == LEVELS-1.

Behaviour:
- Reset values: slow_clk=0, tick=0, freq_num=RESET_LEVEL, at_min/at_max per RESET_LEVEL, divider count=0, synchronisers/shift registers/debounced=0, FSM=IDLE.
- Debounce, per button: 2-flop synchroniser -> DB_DEPTH shift register -> db register.
  - db sets when the shift register is all ones and clears when it is all zeros; otherwise it holds.
  - A clean pin edge reaches db on rising edge DB_DEPTH+3 after the edge.
- Press FSM, shared by both buttons. Inputs are up=db_up&~db_dn and dn=db_dn&~db_up.
  - IDLE: on rising edge of up or dn -> issue one step in that direction, load repeat timer with REPEAT_DLY-1, go to HOLD.
  - HOLD: if the same direction is no longer asserted -> IDLE. Else timer decrements; at 0 -> step, load REPEAT_RATE-1, go to RPT.
  - RPT: same rule as HOLD, but reloads REPEAT_RATE-1 at each step.
  - Both buttons asserted (up=dn=0): FSM returns to IDLE with no step. Releasing one button leaves a level (not an edge) and does not step; a fresh press is needed.
- Level update: one step per FSM step cycle, applied on the next edge.
  - Up at LEVELS-1 and down at 0 saturate: no change, no wrap.
  - freq_num, at_min and at_max update in the same cycle.
- Divider: half-period H(L) = BASE_HALF << (LEVELS-1-L), so level LEVELS-1 is fastest.
  - Counter runs 0..H_act-1. At H_act-1: counter -> 0, slow_clk toggles; tick=1 for that cycle if slow_clk goes 0->1.
  - H_act is latched from freq_num only at wrap (and at reset). Level changes never truncate or stretch the current half-period; the new rate starts at the next half-period boundary.
  - First slow_clk rise after reset occurs at edge H(RESET_LEVEL).
- Reset mid-operation: immediate asynchronous return to reset values. A button held across reset deassertion needs DB_DEPTH+3 cycles, then counts as a new press.

Test Plan:
- Sim params DB_DEPTH=4, LEVELS=6, BASE_HALF=2, REPEAT_DLY=20, REPEAT_RATE=8.
- Reset then idle 300 cycles -> freq_num=0, at_min=1, slow_clk period 128 cycles (64 high/64 low), tick every 128 cycles.
- Single up press held 10 cycles with 3 cycles of bounce at start -> db_up rises exactly once, freq_num 0->1 once, no repeat.
- Up held 60 cycles from level 0 -> steps at press, +20, +28, +36, +44 cycles; freq_num reaches 5 at the +44 step; at_max=1; further hold gives no change and no wrap.
- At level 5 (half-period 2), press down mid half-period -> current half-period completes at 2 cycles, next half-period is 4 cycles; no glitch or runt on slow_clk.
- Both buttons pressed together, then up released -> freq_num unchanged throughout; FSM in IDLE.
- reset pulsed during auto-repeat at level 3 -> freq_num=RESET_LEVEL, slow_clk=0 immediately; still-held up yields one step DB_DEPTH+3 cycles after reset deassertion.
